// File: rtl/sysarr_ws_array_pkg.sv
// ---------------------------------------------------------------------------
// sysarr_ws_array_pkg
// Shared types, constants and helpers for the weight-stationary systolic
// array. Optional build macro: SYSARR_SATURATE_EN (enables sat_add use).
// ---------------------------------------------------------------------------
package sysarr_ws_array_pkg;

    // Default element and accumulator widths
    localparam int unsigned SYSARR_DW = 16;
    localparam int unsigned SYSARR_AW = 32;

    // One PE pipeline stage at the default widths
    typedef struct packed {
        logic                        valid;
        logic signed [SYSARR_DW-1:0] act;
        logic signed [SYSARR_AW-1:0] psum;
    } pe_rec_t;

    // Accept-to-FIFO-write latency in cycles
    function automatic int unsigned sysarr_ws_lat(input int unsigned rows,
                                                  input int unsigned cols);
        return rows + cols;
    endfunction

    // Signed add clamped to the range of an aw-bit two's complement value (aw <= 63)
    function automatic logic signed [63:0] sat_add(input logic signed [63:0] a,
                                                   input logic signed [63:0] b,
                                                   input int unsigned        aw);
        logic signed [64:0] sum;
        logic signed [64:0] hi;
        logic signed [64:0] lo;
        sum = 65'(a) + 65'(b);
        hi  = (65'sd1 <<< (aw - 1)) - 65'sd1;
        lo  = -(65'sd1 <<< (aw - 1));
        if (sum > hi) begin
            return 64'(hi);
        end
        if (sum < lo) begin
            return 64'(lo);
        end
        return 64'(sum);
    endfunction

endpackage

// File: rtl/sysarr_ws_array_pe.sv
// ---------------------------------------------------------------------------
// sysarr_ws_pe
// One weight-stationary processing element: holds a weight, passes the
// activation right and the multiply-accumulated partial sum down, one
// register stage each. Optional build macro: SYSARR_SATURATE_EN.
// Ports:
//   clk, nRST          clock, async active-low reset
//   w_we, w_din        weight write enable / value
//   act_in, act_out    activation from the left / to the right
//   psum_in, psum_out  partial sum from above / to below
//   valid_in, valid_out stage valid bit travelling with the partial sum
// ---------------------------------------------------------------------------
module sysarr_ws_pe
    import sysarr_ws_array_pkg::*;
#(
    parameter int unsigned DW = SYSARR_DW,
    parameter int unsigned AW = SYSARR_AW
) (
    input  logic                 clk,
    input  logic                 nRST,
    input  logic                 w_we,
    input  logic signed [DW-1:0] w_din,
    input  logic signed [DW-1:0] act_in,
    input  logic signed [AW-1:0] psum_in,
    input  logic                 valid_in,
    output logic signed [DW-1:0] act_out,
    output logic signed [AW-1:0] psum_out,
    output logic                 valid_out
);

    localparam int unsigned PW = 2 * DW;

    logic signed [DW-1:0] w_q;
    logic signed [PW-1:0] prod_c;
    logic signed [AW-1:0] prod_ext_c;
    logic signed [AW-1:0] mac_c;

    // Full-precision signed product, sign-extended to the accumulator width
    assign prod_c     = PW'(act_in) * PW'(w_q);
    assign prod_ext_c = AW'(prod_c);

`ifdef SYSARR_SATURATE_EN
    assign mac_c = AW'(sat_add(64'(psum_in), 64'(prod_ext_c), AW));
`else
    assign mac_c = psum_in + prod_ext_c;
`endif

    // Stationary weight
    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            w_q <= '0;
        end else if (w_we) begin
            w_q <= w_din;
        end
    end

    // Pipeline stage
    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            act_out   <= '0;
            psum_out  <= '0;
            valid_out <= 1'b0;
        end else begin
            act_out   <= act_in;
            psum_out  <= mac_c;
            valid_out <= valid_in;
        end
    end

endmodule

// File: rtl/sysarr_ws_array.sv
// ---------------------------------------------------------------------------
// sysarr_ws_array
// ROWS x COLS weight-stationary integer systolic array computing
// y[c] = b[c] + sum_r a[r]*W[r][c], with input skew, output de-skew,
// per-column bias seeding, valid/ready streaming and a credit-protected
// output FIFO. Optional build macro: SYSARR_SATURATE_EN (saturating MAC).
// Ports:
//   clk, nRST                       clock, async active-low reset
//   w_load, w_row, w_data, w_ready  weight row load (only while idle)
//   in_valid, in_ready, in_data, in_bias  activation + bias vector input
//   out_valid, out_ready, out_data  result vector output (FIFO head)
//   busy                            vectors in flight or results buffered
// Element 0 of every vector occupies the most-significant slice.
// ---------------------------------------------------------------------------
module sysarr_ws_array
    import sysarr_ws_array_pkg::*;
#(
    parameter int unsigned ROWS      = 4,
    parameter int unsigned COLS      = 4,
    parameter int unsigned DW        = SYSARR_DW,
    parameter int unsigned AW        = SYSARR_AW,
    parameter int unsigned OUT_DEPTH = 4
) (
    input  logic                      clk,
    input  logic                      nRST,
    input  logic                      w_load,
    input  logic [$clog2(ROWS)-1:0]   w_row,
    input  logic [COLS*DW-1:0]        w_data,
    output logic                      w_ready,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [ROWS*DW-1:0]        in_data,
    input  logic [COLS*AW-1:0]        in_bias,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [COLS*AW-1:0]        out_data,
    output logic                      busy
);

    localparam int unsigned RW      = $clog2(ROWS);
    localparam int unsigned PTR_W   = $clog2(OUT_DEPTH);
    localparam int unsigned CNT_W   = PTR_W + 1;
    localparam int unsigned LAT     = sysarr_ws_lat(ROWS, COLS);
    // De-skew depth for column 0; column c uses DSK_MAX - c stages
    localparam int unsigned DSK_MAX = LAT - ROWS - 1;

    logic                 accept_c;
    logic                 push_c;
    logic                 pop_c;
    logic                 w_load_en_c;
    logic [ROWS-1:0]      w_we_c;
    logic [CNT_W-1:0]     inflight_q;
    logic [CNT_W-1:0]     fifo_cnt_q;
    logic [PTR_W-1:0]     wr_ptr_q;
    logic [PTR_W-1:0]     rd_ptr_q;
    logic [COLS*AW-1:0]   mem_q [OUT_DEPTH];
    logic [COLS*AW-1:0]   res_c;

    // Array interconnect: act_h[r][c] feeds PE(r,c) from the left,
    // psum_v/val_v[r][c] feed PE(r,c) from above
    logic signed [DW-1:0] act_h  [ROWS][COLS+1];
    logic signed [AW-1:0] psum_v [ROWS+1][COLS];
    logic                 val_v  [ROWS+1][COLS];

    logic [ROWS-1:0]      unused_act_c;
    logic [COLS-1:0]      unused_val_c;

    // Handshake and credit logic; weight loads win over vector accepts
    assign in_ready    = !w_load &&
                         ((CNT_W+1)'(fifo_cnt_q) + (CNT_W+1)'(inflight_q) < (CNT_W+1)'(OUT_DEPTH));
    assign w_ready     = (inflight_q == '0);
    assign accept_c    = in_valid && in_ready;
    assign w_load_en_c = w_load && w_ready && (32'(w_row) < ROWS);

    assign out_valid   = (fifo_cnt_q != '0);
    assign pop_c       = out_valid && out_ready;
    assign out_data    = out_valid ? mem_q[rd_ptr_q] : '0;
    assign busy        = (inflight_q != '0) || out_valid;

    // Weight row decode
    for (genvar r = 0; r < ROWS; r++) begin : g_wdec
        assign w_we_c[r] = w_load_en_c && (w_row == RW'(r));
    end

    // Activation skew: row r sees its element r+1 edges after accept
    for (genvar r = 0; r < ROWS; r++) begin : g_askew
        localparam int unsigned D = r + 1;
        logic signed [DW-1:0] sk_q [D];

        always_ff @(posedge clk or negedge nRST) begin
            if (!nRST) begin
                for (int k = 0; k < int'(D); k++) begin
                    sk_q[k] <= '0;
                end
            end else begin
                sk_q[0] <= accept_c ? in_data[(ROWS-1-r)*DW +: DW] : '0;
                for (int k = 1; k < int'(D); k++) begin
                    sk_q[k] <= sk_q[k-1];
                end
            end
        end

        assign act_h[r][0]     = sk_q[D-1];
        assign unused_act_c[r] = ^act_h[r][COLS];
    end

    // Bias skew: column c seed (and its valid bit) delayed c+1 edges
    for (genvar c = 0; c < COLS; c++) begin : g_bskew
        localparam int unsigned D = c + 1;
        logic signed [AW-1:0] bq [D];
        logic                 bv [D];

        always_ff @(posedge clk or negedge nRST) begin
            if (!nRST) begin
                for (int k = 0; k < int'(D); k++) begin
                    bq[k] <= '0;
                    bv[k] <= 1'b0;
                end
            end else begin
                bq[0] <= accept_c ? in_bias[(COLS-1-c)*AW +: AW] : '0;
                bv[0] <= accept_c;
                for (int k = 1; k < int'(D); k++) begin
                    bq[k] <= bq[k-1];
                    bv[k] <= bv[k-1];
                end
            end
        end

        assign psum_v[0][c] = bq[D-1];
        assign val_v[0][c]  = bv[D-1];
    end

    // PE grid
    for (genvar r = 0; r < ROWS; r++) begin : g_row
        for (genvar c = 0; c < COLS; c++) begin : g_col
            sysarr_ws_pe #(
                .DW (DW),
                .AW (AW)
            ) u_pe (
                .clk       (clk),
                .nRST      (nRST),
                .w_we      (w_we_c[r]),
                .w_din     (w_data[(COLS-1-c)*DW +: DW]),
                .act_in    (act_h[r][c]),
                .psum_in   (psum_v[r][c]),
                .valid_in  (val_v[r][c]),
                .act_out   (act_h[r][c+1]),
                .psum_out  (psum_v[r+1][c]),
                .valid_out (val_v[r+1][c])
            );
        end
    end

    // Output de-skew; the last column already arrives aligned and its
    // valid bit marks the whole result vector
    for (genvar c = 0; c < COLS; c++) begin : g_dskew
        if (DSK_MAX - c > 0) begin : g_dly
            localparam int unsigned D = DSK_MAX - c;
            logic signed [AW-1:0] dq [D];

            always_ff @(posedge clk or negedge nRST) begin
                if (!nRST) begin
                    for (int k = 0; k < int'(D); k++) begin
                        dq[k] <= '0;
                    end
                end else begin
                    dq[0] <= psum_v[ROWS][c];
                    for (int k = 1; k < int'(D); k++) begin
                        dq[k] <= dq[k-1];
                    end
                end
            end

            assign res_c[(COLS-1-c)*AW +: AW] = dq[D-1];
            assign unused_val_c[c]            = val_v[ROWS][c];
        end else begin : g_nodly
            assign res_c[(COLS-1-c)*AW +: AW] = psum_v[ROWS][c];
            assign unused_val_c[c]            = 1'b0;
        end
    end

    assign push_c = val_v[ROWS][COLS-1];

    // FIFO storage
    always_ff @(posedge clk) begin
        if (push_c) begin
            mem_q[wr_ptr_q] <= res_c;
        end
    end

    // FIFO pointers, occupancy and in-flight credit count
    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            fifo_cnt_q <= '0;
            inflight_q <= '0;
        end else begin
            if (push_c) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop_c) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            fifo_cnt_q <= fifo_cnt_q + CNT_W'(push_c) - CNT_W'(pop_c);
            inflight_q <= inflight_q + CNT_W'(accept_c) - CNT_W'(push_c);
        end
    end

endmodule

// File: tb/tb_sysarr_ws_array.sv
module tb_sysarr_ws_array;

    localparam int unsigned ROWS      = 4;
    localparam int unsigned COLS      = 4;
    localparam int unsigned DW        = 16;
    localparam int unsigned AW        = 32;
    localparam int unsigned OUT_DEPTH = 4;
    localparam int          MIN32     = -2147483647 - 1;

    logic                    clk = 1'b0;
    logic                    nRST;
    logic                    w_load;
    logic [$clog2(ROWS)-1:0] w_row;
    logic [COLS*DW-1:0]      w_data;
    logic                    w_ready;
    logic                    in_valid;
    logic                    in_ready;
    logic [ROWS*DW-1:0]      in_data;
    logic [COLS*AW-1:0]      in_bias;
    logic                    out_valid;
    logic                    out_ready;
    logic [COLS*AW-1:0]      out_data;
    logic                    busy;

    int n_assert = 0;
    int n_fail   = 0;
    logic [127:0] exp_y [4];
    bit consec;

    always #5 clk = ~clk;

    sysarr_ws_array #(
        .ROWS      (ROWS),
        .COLS      (COLS),
        .DW        (DW),
        .AW        (AW),
        .OUT_DEPTH (OUT_DEPTH)
    ) dut (
        .clk       (clk),
        .nRST      (nRST),
        .w_load    (w_load),
        .w_row     (w_row),
        .w_data    (w_data),
        .w_ready   (w_ready),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_bias   (in_bias),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy)
    );

    function automatic logic [63:0] va(input int a0, input int a1, input int a2, input int a3);
        return {16'(a0), 16'(a1), 16'(a2), 16'(a3)};
    endfunction

    function automatic logic [127:0] vy(input int y0, input int y1, input int y2, input int y3);
        return {32'(y0), 32'(y1), 32'(y2), 32'(y3)};
    endfunction

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_w(input int row, input logic [63:0] data);
        w_load = 1'b1;
        w_row  = 2'(row);
        w_data = data;
        tick();
        w_load = 1'b0;
    endtask

    task automatic send(input logic [63:0] a, input logic [127:0] b);
        in_valid = 1'b1;
        in_data  = a;
        in_bias  = b;
        #1;
        check("send_in_ready", 128'(in_ready), 128'(1));
        tick();
        in_valid = 1'b0;
    endtask

    // Pops up to n results with out_ready held high, comparing against exp_y
    task automatic collect(input int n, input string tag, output bit cons);
        int got;
        int last;
        got  = 0;
        last = -1;
        cons = 1'b1;
        out_ready = 1'b1;
        for (int cyc = 0; cyc < 40; cyc++) begin
            if (out_valid) begin
                if (got < n) begin
                    check(tag, out_data, exp_y[got]);
                end
                if (last >= 0 && cyc != last + 1) begin
                    cons = 1'b0;
                end
                last = cyc;
                got++;
            end
            tick();
        end
        out_ready = 1'b0;
        check({tag, "_count"}, 128'(got), 128'(n));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        nRST = 1'b1; w_load = 1'b0; w_row = '0; w_data = '0;
        in_valid = 1'b0; in_data = '0; in_bias = '0; out_ready = 1'b0;
        #2 nRST = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_w_ready",   128'(w_ready),   128'(1));
        check("rst_in_ready",  128'(in_ready),  128'(1));
        check("rst_out_valid", 128'(out_valid), 128'(0));
        check("rst_out_data",  128'(out_data),  128'(0));
        check("rst_busy",      128'(busy),      128'(0));
        nRST = 1'b1;
        tick();

        // 1: identity weights, exact latency
        load_w(0, va(1, 0, 0, 0));
        load_w(1, va(0, 1, 0, 0));
        load_w(2, va(0, 0, 1, 0));
        load_w(3, va(0, 0, 0, 1));
        send(va(1, 2, 3, 4), vy(10, 10, 10, 10));
        repeat (7) tick();
        check("t1_not_yet_valid", 128'(out_valid), 128'(0));
        check("t1_busy_inflight", 128'(busy),      128'(1));
        tick();
        check("t1_valid_at_lat", 128'(out_valid), 128'(1));
        check("t1_data",         out_data,        vy(11, 12, 13, 14));
        tick();
        check("t1_hold",         out_data,        vy(11, 12, 13, 14));
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("t1_empty_valid",  128'(out_valid), 128'(0));
        check("t1_empty_data",   128'(out_data),  128'(0));
        check("t1_idle_busy",    128'(busy),      128'(0));

        // 2: back-to-back stream
        exp_y[0] = vy(1, 2, 3, 4);
        exp_y[1] = vy(95, 206, 293, 408);
        exp_y[2] = vy(1001, -999, 32768, -32767);
        exp_y[3] = vy(-1, -2, -3, -4);
        send(va(1, 2, 3, 4),                vy(0, 0, 0, 0));
        send(va(-5, 6, -7, 8),              vy(100, 200, 300, 400));
        send(va(1000, -1000, 32767, -32768), vy(1, 1, 1, 1));
        send(va(0, 0, 0, 0),                vy(-1, -2, -3, -4));
        collect(4, "t2_data", consec);
        check("t2_consecutive", 128'(consec), 128'(1));
        check("t2_busy_end",    128'(busy),   128'(0));

        // General weight matrix for the remaining tests
        load_w(0, va(1, 2, 3, 4));
        load_w(1, va(-1, 0, 1, 2));
        load_w(2, va(2, 2, 2, 2));
        load_w(3, va(0, -3, 5, 1));

        // 3: credit back-pressure with out_ready low
        exp_y[0] = vy(2, 1, 11, 9);
        exp_y[1] = vy(15, 16, 61, 58);
        exp_y[2] = vy(-1, -2, -3, -4);
        exp_y[3] = vy(5, -1, 15, 7);
        send(va(1, 1, 1, 1),  vy(0, 0, 0, 0));
        send(va(1, 2, 3, 4),  vy(10, 20, 30, 40));
        send(va(-1, 0, 0, 0), vy(0, 0, 0, 0));
        send(va(0, 0, 0, 2),  vy(5, 5, 5, 5));
        in_valid = 1'b1;
        in_data  = va(9, 9, 9, 9);
        in_bias  = vy(9, 9, 9, 9);
        #1;
        check("t3_no_credit_early", 128'(in_ready), 128'(0));
        repeat (12) tick();
        check("t3_no_credit_full",  128'(in_ready),  128'(0));
        check("t3_full_valid",      128'(out_valid), 128'(1));
        check("t3_head",            out_data,        vy(2, 1, 11, 9));
        in_valid = 1'b0;
        collect(4, "t3_data", consec);
        check("t3_consecutive",     128'(consec),    128'(1));
        check("t3_credit_back",     128'(in_ready),  128'(1));
        check("t3_busy_end",        128'(busy),      128'(0));

        // 4: weight load refused while a vector is in flight
        send(va(1, 2, 3, 4), vy(10, 20, 30, 40));
        w_load = 1'b1;
        w_row  = 2'(0);
        w_data = va(99, 99, 99, 99);
        #1;
        check("t4_w_ready_low",  128'(w_ready),  128'(0));
        check("t4_in_ready_low", 128'(in_ready), 128'(0));
        tick();
        w_load = 1'b0;
        exp_y[0] = vy(15, 16, 61, 58);
        collect(1, "t4_old_w_inflight", consec);
        check("t4_w_ready_idle", 128'(w_ready), 128'(1));
        send(va(1, 1, 1, 1), vy(0, 0, 0, 0));
        exp_y[0] = vy(2, 1, 11, 9);
        collect(1, "t4_old_w_after", consec);

        // 5: signed extremes
        for (int r = 0; r < 4; r++) begin
            load_w(r, va(-32768, -32768, -32768, -32768));
        end
        send(va(-32768, -32768, -32768, -32768), vy(0, 0, 0, 0));
        send(va(-32768, -32768, 0, 0),           vy(0, 0, 0, 0));
`ifdef SYSARR_SATURATE_EN
        exp_y[0] = vy(2147483647, 2147483647, 2147483647, 2147483647);
        exp_y[1] = vy(2147483647, 2147483647, 2147483647, 2147483647);
`else
        exp_y[0] = vy(0, 0, 0, 0);
        exp_y[1] = vy(MIN32, MIN32, MIN32, MIN32);
`endif
        collect(2, "t5_extreme", consec);

        // 6: reset with one result buffered and one in flight
        send(va(1, 1, 1, 1), vy(0, 0, 0, 0));
        repeat (9) tick();
        check("t6_buffered", 128'(out_valid), 128'(1));
        send(va(2, 2, 2, 2), vy(0, 0, 0, 0));
        tick();
        check("t6_busy_pre", 128'(busy), 128'(1));
        nRST = 1'b0;
        #1;
        check("t6_rst_w_ready",   128'(w_ready),   128'(1));
        check("t6_rst_in_ready",  128'(in_ready),  128'(1));
        check("t6_rst_out_valid", 128'(out_valid), 128'(0));
        check("t6_rst_out_data",  128'(out_data),  128'(0));
        check("t6_rst_busy",      128'(busy),      128'(0));
        tick();
        nRST = 1'b1;
        tick();
        send(va(1, 2, 3, 4), vy(7, 8, 9, 10));
        repeat (7) tick();
        check("t6_not_yet_valid", 128'(out_valid), 128'(0));
        tick();
        check("t6_valid",         128'(out_valid), 128'(1));
        check("t6_zero_weights",  out_data,        vy(7, 8, 9, 10));
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("t6_busy_end",      128'(busy),      128'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
